// File: rtl/vec_mem_sequencer.sv
// Sequences VLD/VST/SST element accesses onto a single-ported req/gnt data memory
// and writes each assembled load vector back to the vector register file.
`timescale 1ns/1ps
module vec_mem_sequencer #(
  parameter int VLEN   = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [3:0]               functype,
  input  logic [ADDR_W-1:0]        base,
  input  logic [5:0]               offset,
  input  logic [2:0]               dst_addr,
  input  logic [VLEN*DATA_W-1:0]   vst_data,
  input  logic [DATA_W-1:0]        sst_data,
  output logic                     busy,
  output logic                     done,
  output logic                     start_err,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_gnt,
  input  logic                     mem_rvalid,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     vwr_en,
  output logic [2:0]               vwr_addr,
  output logic [VLEN*DATA_W-1:0]   vwr_data
);

  localparam int CNT_W = $clog2(VLEN + 1);
  localparam int IDX_W = (VLEN > 1) ? $clog2(VLEN) : 1;
  localparam logic [3:0]        FT_VLD   = 4'b0100;
  localparam logic [3:0]        FT_VST   = 4'b0101;
  localparam logic [3:0]        FT_SST   = 4'b0011;
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_VLEN = CNT_W'(VLEN);
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT_RD = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                         state_r;
  logic [3:0]                     func_r;
  logic [2:0]                     dst_r;
  logic [VLEN-1:0][DATA_W-1:0]    vst_r;
  logic [DATA_W-1:0]              sst_r;
  logic [CNT_W-1:0]               iss_cnt_r;
  logic [CNT_W-1:0]               rcv_cnt_r;
  logic [VLEN-1:0][DATA_W-1:0]    ld_vec_r;

  logic                           is_vld_s;
  logic                           op_ok_s;
  logic [CNT_W-1:0]               n_elem_s;
  logic [CNT_W-1:0]               iss_next_s;
  logic                           last_gnt_s;
  logic                           rcv_hit_s;
  logic                           rcv_done_s;
  logic [ADDR_W-1:0]              first_addr_s;
  logic [DATA_W-1:0]              first_wdata_s;
  logic [DATA_W-1:0]              next_wdata_s;
  logic [VLEN-1:0][DATA_W-1:0]    ld_vec_s;

  // Element bookkeeping, next request data and in-order load slot capture
  always_comb begin
    is_vld_s     = (func_r == FT_VLD);
    op_ok_s      = (functype == FT_VLD) || (functype == FT_VST) || (functype == FT_SST);
    n_elem_s     = (func_r == FT_SST) ? CNT_ONE : CNT_VLEN;
    iss_next_s   = iss_cnt_r + CNT_ONE;
    last_gnt_s   = (state_r == S_ISSUE) && mem_gnt && (iss_next_s == n_elem_s);
    first_addr_s = base + {{(ADDR_W-6){1'b0}}, offset};

    if (functype == FT_VST) begin
      first_wdata_s = vst_data[DATA_W-1:0];
    end else if (functype == FT_SST) begin
      first_wdata_s = sst_data;
    end else begin
      first_wdata_s = {DATA_W{1'b0}};
    end

    if (func_r == FT_SST) begin
      next_wdata_s = sst_r;
    end else if (func_r == FT_VST) begin
      next_wdata_s = vst_r[iss_next_s[IDX_W-1:0]];
    end else begin
      next_wdata_s = {DATA_W{1'b0}};
    end

    // Responses are accepted while issuing too, since memory may answer before the last grant
    rcv_hit_s  = mem_rvalid && is_vld_s && (rcv_cnt_r < CNT_VLEN) &&
                 ((state_r == S_ISSUE) || (state_r == S_WAIT_RD));
    rcv_done_s = rcv_hit_s && (rcv_cnt_r == (CNT_VLEN - CNT_ONE));

    ld_vec_s = ld_vec_r;
    if (rcv_hit_s) begin
      ld_vec_s[rcv_cnt_r[IDX_W-1:0]] = mem_rdata;
    end else begin
      ld_vec_s = ld_vec_r;
    end
  end

  // Sequencer FSM with registered outputs, operand latches and load assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      func_r    <= 4'b0000;
      dst_r     <= 3'b000;
      vst_r     <= {(VLEN*DATA_W){1'b0}};
      sst_r     <= {DATA_W{1'b0}};
      iss_cnt_r <= {CNT_W{1'b0}};
      rcv_cnt_r <= {CNT_W{1'b0}};
      ld_vec_r  <= {(VLEN*DATA_W){1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
      start_err <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= {DATA_W{1'b0}};
      vwr_en    <= 1'b0;
      vwr_addr  <= 3'b000;
      vwr_data  <= {(VLEN*DATA_W){1'b0}};
    end else begin
      done      <= 1'b0;
      vwr_en    <= 1'b0;
      start_err <= start && (state_r != S_IDLE);
      if (rcv_hit_s) begin
        ld_vec_r  <= ld_vec_s;
        rcv_cnt_r <= rcv_cnt_r + CNT_ONE;
      end
      case (state_r)
        S_IDLE: begin
          if (start && op_ok_s) begin
            func_r    <= functype;
            dst_r     <= dst_addr;
            vst_r     <= vst_data;
            sst_r     <= sst_data;
            iss_cnt_r <= {CNT_W{1'b0}};
            rcv_cnt_r <= {CNT_W{1'b0}};
            ld_vec_r  <= {(VLEN*DATA_W){1'b0}};
            busy      <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= (functype != FT_VLD);
            mem_addr  <= first_addr_s;
            mem_wdata <= first_wdata_s;
            state_r   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mem_gnt) begin
            iss_cnt_r <= iss_next_s;
            mem_addr  <= mem_addr + ADDR_ONE;
            mem_wdata <= next_wdata_s;
            if (last_gnt_s) begin
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
              if (!is_vld_s) begin
                done    <= 1'b1;
                state_r <= S_DONE;
              end else if (rcv_done_s) begin
                done     <= 1'b1;
                vwr_en   <= 1'b1;
                vwr_addr <= dst_r;
                vwr_data <= ld_vec_s;
                state_r  <= S_DONE;
              end else begin
                state_r <= S_WAIT_RD;
              end
            end
          end
        end
        S_WAIT_RD: begin
          if (rcv_done_s) begin
            done     <= 1'b1;
            vwr_en   <= 1'b1;
            vwr_addr <= dst_r;
            vwr_data <= ld_vec_s;
            state_r  <= S_DONE;
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule
